// File: rtl/adc_capture.sv
// Dual-channel ADC acquisition front end: decimates both channels, records a circular
// pre-trigger history, fills the post-trigger part, then freezes and reports a status word.
module adc_capture #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] adc_a,
  input  logic [DW-1:0] adc_b,
  input  logic [31:0]   adc_cfg,
  input  logic          arm,
  output logic [AW-1:0] wr_addr,
  output logic [2*DW-1:0] wr_data,
  output logic          wr_en,
  output logic [15:0]   status,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_d;

  logic [DW-1:0] s1_a, s1_b;
  logic [DW-1:0] level_q;
  logic          edge_q, src_q, auto_q;
  logic [3:0]    dec_q;
  logic [AW-1:0] pretrig_q;

  logic [15:0]   dec_cnt;
  logic [AW-1:0] ptr, pre_cnt, post_cnt, trig_addr;
  logic [DW-1:0] prev;
  logic          prev_ok, triggered;

  logic          running, strobe, edge_hit, hit;
  logic [15:0]   dec_mask;
  logic [DW-1:0] sel;
  logic [AW-1:0] post_total;
  logic          unused_cfg_bits;

  assign unused_cfg_bits = ^{adc_cfg[31:28], adc_cfg[15]};

  assign running    = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign dec_mask   = (16'd1 << dec_q) - 16'd1;
  // An arm on the same cycle as a strobe wins, so that write never happens.
  assign strobe     = running && !arm && (dec_cnt == dec_mask);
  assign sel        = src_q ? s1_b : s1_a;
  assign post_total = ~pretrig_q;
  assign edge_hit   = prev_ok && (edge_q ? ((prev > level_q) && (sel <= level_q))
                                         : ((prev < level_q) && (sel >= level_q)));
  assign hit        = edge_hit || (auto_q && !prev_ok);

  assign status = {state, triggered, 12'(trig_addr)};
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (arm) begin
      state_d = (adc_cfg[16 +: AW] == '0) ? S_WAIT : S_PRE;
    end else if (strobe) begin
      case (state)
        S_PRE:   if (pre_cnt == pretrig_q - AW'(1)) state_d = S_WAIT;
        S_WAIT:  if (hit) state_d = (post_total == '0) ? S_DONE : S_POST;
        S_POST:  if (post_cnt == post_total - AW'(1)) state_d = S_DONE;
        default: state_d = state;
      endcase
    end
  end

  // Datapath: input register, decimation counter, buffer write port and trigger bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a      <= '0;
      s1_b      <= '0;
      level_q   <= '0;
      edge_q    <= 1'b0;
      src_q     <= 1'b0;
      auto_q    <= 1'b0;
      dec_q     <= '0;
      pretrig_q <= '0;
      dec_cnt   <= '0;
      ptr       <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
      triggered <= 1'b0;
      trig_addr <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
    end else begin
      s1_a  <= adc_a;
      s1_b  <= adc_b;
      wr_en <= strobe;
      if (arm) begin
        level_q   <= adc_cfg[7:0];
        edge_q    <= adc_cfg[8];
        src_q     <= adc_cfg[9];
        auto_q    <= adc_cfg[10];
        dec_q     <= adc_cfg[14:11];
        pretrig_q <= adc_cfg[16 +: AW];
        dec_cnt   <= '0;
        ptr       <= '0;
        wr_addr   <= '0;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        prev_ok   <= 1'b0;
        triggered <= 1'b0;
        trig_addr <= '0;
      end else if (running) begin
        dec_cnt <= strobe ? 16'd0 : dec_cnt + 16'd1;
        if (strobe) begin
          wr_addr <= ptr;
          wr_data <= {s1_b, s1_a};
          ptr     <= ptr + AW'(1);
          case (state)
            S_PRE:  pre_cnt <= pre_cnt + AW'(1);
            S_WAIT: begin
              prev    <= sel;
              prev_ok <= 1'b1;
              if (hit) begin
                triggered <= 1'b1;
                trig_addr <= ptr;
              end
            end
            S_POST: post_cnt <= post_cnt + AW'(1);
            default: ;
          endcase
        end
      end
    end
  end

endmodule
